// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream with 3-entry prefetch
// Optional transfer counter output rd_count enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    logic [DATA_WIDTH-1:0] r_buf [3];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_occ;
    logic                  r_inflight;

    logic [2:0]            w_fill;
    logic                  w_capture;
    logic                  w_transfer;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit check counts the in-flight word so the buffer can never overflow.
    assign w_fill     = {1'b0, r_occ} + {2'b00, r_inflight};
    assign fifo_rinc  = rrst_n & ~fifo_rempty & ~flush & (w_fill < 3'd3);
    assign w_capture  = r_inflight & ~flush;
    assign m_valid    = (r_occ != 2'd0);
    assign w_transfer = m_valid & m_ready;
    assign m_data     = (r_head == 2'd2) ? r_buf[2] :
                        (r_head == 2'd1) ? r_buf[1] : r_buf[0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rinc;
            if (w_capture) begin
                for (int i = 0; i < 3; i++) begin
                    if (r_tail == 2'(i)) begin
                        r_buf[i] <= fifo_rdata;
                    end
                end
                r_tail <= ptr_next(r_tail);
            end
            if (w_transfer) begin
                r_head <= ptr_next(r_head);
            end
            r_occ <= r_occ + {1'b0, w_capture} - {1'b0, w_transfer};
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] r_rd_count;

    // Counts every accepted word, including one taken in a flush cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rd_count <= 16'd0;
        end else if (w_transfer) begin
            r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    logic       rclk;
    logic       rrst_n;
    logic       fifo_rempty;
    logic [7:0] fifo_rdata;
    logic       fifo_rinc;
    logic       flush;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .rd_count    (rd_count)
`endif
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q  [$];
    logic [7:0] rx [$];
    int         pops;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_rinc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(first + 8'(i));
        end
        fifo_rempty = (q.size() == 0);
    endtask

    // One clock: sample DUT on the falling edge, then model the FIFO's registered read.
    task automatic step();
        @(negedge rclk);
        s_valid = m_valid;
        s_data  = m_data;
        s_rinc  = fifo_rinc;
        if (s_rinc) pops++;
        if (s_valid && m_ready && rrst_n) rx.push_back(s_data);
        @(posedge rclk);
        #1;
        if (s_rinc) fifo_rdata = q.pop_front();
        fifo_rempty = (q.size() == 0);
    endtask

    initial begin
        int   vcount;
        logic have_prev;
        logic [7:0] prev;

        rrst_n      = 1'b0;
        fifo_rempty = 1'b1;
        fifo_rdata  = 8'h00;
        flush       = 1'b0;
        m_ready     = 1'b0;
        pops        = 0;
        step();
        step();
        check("rst_valid", {31'd0, s_valid}, 0);
        check("rst_data", {24'd0, s_data}, 0);
        check("rst_rinc", {31'd0, s_rinc}, 0);
        rrst_n = 1'b1;

        // Burst: 8 words, ready held high
        rx.delete(); pops = 0;
        m_ready = 1'b1;
        load(8'h01, 8);
        for (int c = 0; c < 12; c++) begin
            step();
            check("burst_valid", {31'd0, s_valid}, (c >= 2 && c <= 9) ? 1 : 0);
            if (c >= 2 && c <= 9) check("burst_data", {24'd0, s_data}, c - 1);
        end

        // Backpressure: 5 words, ready low for 10 cycles
        rx.delete(); pops = 0;
        m_ready = 1'b0;
        load(8'h01, 5);
        for (int c = 0; c < 10; c++) step();
        check("bp_pops", pops, 3);
        check("bp_rinc", {31'd0, s_rinc}, 0);
        check("bp_valid", {31'd0, s_valid}, 1);
        check("bp_data", {24'd0, s_data}, 8'h01);
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_rel_valid", {31'd0, s_valid}, 1);
            check("bp_rel_data", {24'd0, s_data}, c + 1);
        end
        step();
        check("bp_drained", {31'd0, s_valid}, 0);

        // Ready toggling 1,0,1,0 over 6 words
        rx.delete(); pops = 0;
        have_prev = 1'b0;
        prev = 8'h00;
        load(8'hA0, 6);
        for (int c = 0; c < 40 && rx.size() < 6; c++) begin
            m_ready = (c % 2 == 0);
            step();
            if (have_prev) begin
                check("tog_stall_valid", {31'd0, s_valid}, 1);
                check("tog_stall_data", {24'd0, s_data}, {24'd0, prev});
            end
            have_prev = s_valid && !m_ready;
            prev      = s_data;
        end
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("tog_count", rx.size(), 6);
        for (int i = 0; i < 6 && i < rx.size(); i++) check("tog_data", {24'd0, rx[i]}, 8'hA0 + i);

        // Single word, FIFO empty again right after
        rx.delete(); pops = 0; vcount = 0;
        load(8'h5A, 1);
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_valid) vcount++;
            if (c == 2) check("one_valid_c2", {31'd0, s_valid}, 1);
        end
        check("one_pops", pops, 1);
        check("one_vcycles", vcount, 1);
        check("one_data", rx.size() > 0 ? {24'd0, rx[0]} : 32'hFFFF_FFFF, 8'h5A);

        // Flush with occ=2 and one word in flight
        rx.delete(); pops = 0;
        m_ready = 1'b0;
        load(8'h10, 6);
        for (int c = 0; c < 3; c++) step();
        flush = 1'b1;
        step();
        check("fl_cyc_valid", {31'd0, s_valid}, 1);
        check("fl_cyc_rinc", {31'd0, s_rinc}, 0);
        m_ready = 1'b1;
        step();
        check("fl_next_valid", {31'd0, s_valid}, 0);
        check("fl_nonempty_rinc", {31'd0, s_rinc}, 0);
        flush = 1'b0;
        for (int c = 0; c < 8; c++) step();
        check("fl_count", rx.size(), 3);
        for (int i = 0; i < 3 && i < rx.size(); i++) check("fl_data", {24'd0, rx[i]}, 8'h13 + i);

        // Reset with a full prefetch buffer
        rx.delete(); pops = 0;
        m_ready = 1'b0;
        load(8'h31, 5);
        for (int c = 0; c < 4; c++) step();
        check("mr_pre_valid", {31'd0, m_valid}, 1);
        rrst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, m_valid}, 0);
        check("mr_data", {24'd0, m_data}, 0);
        check("mr_rinc", {31'd0, fifo_rinc}, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("mr_count", {16'd0, rd_count}, 0);
`endif
        step();
        step();
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        check("mr_rx_count", rx.size(), 2);
        for (int i = 0; i < 2 && i < rx.size(); i++) check("mr_rx_data", {24'd0, rx[i]}, 8'h34 + i);

`ifdef FIFO_RD_STREAM_CNT_EN
        check("cnt_after_2", {16'd0, rd_count}, 2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flush_keep", {16'd0, rd_count}, 2);
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        rx.delete();
        load(8'h00, 65535);
        for (int c = 0; c < 65539; c++) begin
            step();
            if (rx.size() > 4) rx.delete();
        end
        check("cnt_ffff", {16'd0, rd_count}, 32'h0000_FFFF);
        load(8'h77, 1);
        for (int c = 0; c < 5; c++) step();
        check("cnt_wrap", {16'd0, rd_count}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
